// File: rtl/lstm_matvec_sequencer.sv
// Sequencer for a 16-lane inner-product datapath: issues chunk reads per row,
// accumulates the 2-cycle-delayed results and hands saturated rows downstream.
module lstm_matvec_sequencer #(
  parameter int unsigned BIT_WIDTH = 8,
  parameter int unsigned ROW_W     = 8,
  parameter int unsigned CHUNK_W   = 4,
  parameter int unsigned ACC_WIDTH = 12,
  parameter int unsigned ADDR_W    = ROW_W + CHUNK_W
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 iStart,
  input  logic [ROW_W-1:0]     iNumRows,
  input  logic [CHUNK_W-1:0]   iNumChunks,
  output logic                 oBusy,
  output logic                 oDone,
  output logic                 oRdEn,
  output logic [ADDR_W-1:0]    oWAddr,
  output logic [CHUNK_W-1:0]   oXAddr,
  input  logic [BIT_WIDTH-1:0] iInner,
  output logic                 oRowValid,
  output logic [BIT_WIDTH-1:0] oRowData,
  output logic [ROW_W-1:0]     oRowIdx,
  input  logic                 iRowReady
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_DRAIN = 3'd2,
    S_OUT   = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((2 ** (BIT_WIDTH - 1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  function automatic logic [BIT_WIDTH-1:0] sat(input logic signed [ACC_WIDTH-1:0] a);
    if (a > SAT_MAX) begin
      return {1'b0, {(BIT_WIDTH-1){1'b1}}};
    end else if (a < SAT_MIN) begin
      return {1'b1, {(BIT_WIDTH-1){1'b0}}};
    end
    return a[BIT_WIDTH-1:0];
  endfunction

  state_e                       state_q, state_d;
  logic [ROW_W-1:0]             nr_q, nr_d;
  logic [CHUNK_W-1:0]           nc_q, nc_d;
  logic [ROW_W-1:0]             row_q, row_d;
  logic [CHUNK_W-1:0]           chunk_q, chunk_d;
  logic [ADDR_W-1:0]            waddr_q, waddr_d;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [BIT_WIDTH-1:0]         data_q, data_d;
  logic                         drain_q, drain_d;
  logic [1:0]                   pipe_q;
  logic                         busy_q, done_q, rd_q, valid_q;

  // Next-state, counters and accumulator update
  always_comb begin
    state_d = state_q;
    nr_d    = nr_q;
    nc_d    = nc_q;
    row_d   = row_q;
    chunk_d = chunk_q;
    waddr_d = waddr_q;
    drain_d = drain_q;
    data_d  = data_q;
    acc_d   = acc_q;
    if (pipe_q[1]) begin
      acc_d = acc_q + ACC_WIDTH'($signed(iInner));
    end
    case (state_q)
      S_IDLE: begin
        if (iStart) begin
          if ((iNumRows != '0) && (iNumChunks != '0)) begin
            state_d = S_ISSUE;
            nr_d    = iNumRows;
            nc_d    = iNumChunks;
            row_d   = '0;
            chunk_d = '0;
            waddr_d = '0;
            acc_d   = '0;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_ISSUE: begin
        waddr_d = waddr_q + ADDR_W'(1);
        if (chunk_q == nc_q - CHUNK_W'(1)) begin
          chunk_d = '0;
          drain_d = 1'b0;
          state_d = S_DRAIN;
        end else begin
          chunk_d = chunk_q + CHUNK_W'(1);
        end
      end
      S_DRAIN: begin
        // Second drain cycle carries the last sample; acc_d already includes it
        if (drain_q) begin
          state_d = S_OUT;
          data_d  = sat(acc_d);
        end else begin
          drain_d = 1'b1;
        end
      end
      S_OUT: begin
        if (iRowReady) begin
          if (row_q == nr_q - ROW_W'(1)) begin
            state_d = S_DONE;
          end else begin
            row_d   = row_q + ROW_W'(1);
            acc_d   = '0;
            state_d = S_ISSUE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      nr_q    <= '0;
      nc_q    <= '0;
      row_q   <= '0;
      chunk_q <= '0;
      waddr_q <= '0;
      acc_q   <= '0;
      data_q  <= '0;
      drain_q <= 1'b0;
      pipe_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_q    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      nr_q    <= nr_d;
      nc_q    <= nc_d;
      row_q   <= row_d;
      chunk_q <= chunk_d;
      waddr_q <= waddr_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      drain_q <= drain_d;
      pipe_q  <= {pipe_q[0], rd_q};
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_DONE);
      rd_q    <= (state_d == S_ISSUE);
      valid_q <= (state_d == S_OUT);
    end
  end

  assign oBusy     = busy_q;
  assign oDone     = done_q;
  assign oRdEn     = rd_q;
  assign oWAddr    = waddr_q;
  assign oXAddr    = chunk_q;
  assign oRowValid = valid_q;
  assign oRowData  = data_q;
  assign oRowIdx   = row_q;

endmodule

// File: tb/tb_lstm_matvec_sequencer.sv
// Bench for lstm_matvec_sequencer: emulates the datapath from a value table and
// checks every cycle against a job-timeline model plus literal expectations.
module tb_lstm_matvec_sequencer;

  logic        clk, resetn, iStart;
  logic [7:0]  iNumRows;
  logic [3:0]  iNumChunks;
  logic        oBusy, oDone, oRdEn;
  logic [11:0] oWAddr;
  logic [3:0]  oXAddr;
  logic [7:0]  iInner;
  logic        oRowValid;
  logic [7:0]  oRowData;
  logic [7:0]  oRowIdx;
  logic        iRowReady;

  lstm_matvec_sequencer dut (
    .clk(clk), .resetn(resetn), .iStart(iStart), .iNumRows(iNumRows),
    .iNumChunks(iNumChunks), .oBusy(oBusy), .oDone(oDone), .oRdEn(oRdEn),
    .oWAddr(oWAddr), .oXAddr(oXAddr), .iInner(iInner), .oRowValid(oRowValid),
    .oRowData(oRowData), .oRowIdx(oRowIdx), .iRowReady(iRowReady)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Datapath stand-in: value for weight address a is vals[a]
  int         vals [0:4095];
  logic [7:0] exp_row [0:255];
  logic [7:0] s1 = 8'd0, s2 = 8'd0;
  int         rdy_mode = 0;
  int         stall_left = 0;

  function automatic logic [7:0] sat8(input int s);
    if (s > 127) return 8'd127;
    if (s < -128) return 8'h80;
    return 8'(s);
  endfunction

  function automatic void prep_job(input int nr, input int nc);
    for (int r = 0; r < nr; r++) begin
      int s = 0;
      for (int c = 0; c < nc; c++) s += vals[r*nc + c];
      exp_row[r] = sat8(s);
    end
  endfunction

  initial begin
    iInner = 8'd0;
    forever begin
      @(posedge clk);
      #1;
      iInner = s2;
      s2 = s1;
      s1 = oRdEn ? 8'(vals[oWAddr]) : 8'($urandom);
    end
  end

  initial begin
    iRowReady = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: iRowReady = 1'b1;
        1: iRowReady = 1'($urandom_range(0, 1));
        default: begin
          if (oRowValid && stall_left > 0) begin
            iRowReady = 1'b0;
            stall_left--;
          end else begin
            iRowReady = 1'b1;
          end
        end
      endcase
    end
  end

  // Timeline model: row r issues NC cycles from its start, is valid from
  // start+NC+2 until accepted, next row starts the cycle after acceptance.
  bit m_active = 0;
  int m_t, m_nr, m_nc, m_row, m_rs, m_done_t, m_rdc;
  int jobs_started = 0, jobs_done = 0;
  int cap_first_rd, cap_first_valid, cap_done_t;
  int cap_waddr[$], cap_xaddr[$], cap_idx[$], cap_data[$], cap_hs[$], cap_rs[$];

  always @(negedge clk) begin
    if (!resetn) begin
      chk("rst_busy", int'(oBusy), 0);
      chk("rst_rden", int'(oRdEn), 0);
      chk("rst_valid", int'(oRowValid), 0);
      chk("rst_done", int'(oDone), 0);
      chk("rst_waddr", int'(oWAddr), 0);
      chk("rst_xaddr", int'(oXAddr), 0);
      chk("rst_data", int'(oRowData), 0);
      chk("rst_idx", int'(oRowIdx), 0);
      m_active = 0;
    end else if (m_active) begin
      bit zero, e_rd, e_valid, e_done;
      m_t++;
      zero    = (m_nr == 0) || (m_nc == 0);
      e_rd    = !zero && (m_t >= m_rs) && (m_t < m_rs + m_nc);
      e_valid = !zero && (m_done_t < 0) && (m_t >= m_rs + m_nc + 2);
      e_done  = (m_t == m_done_t);
      chk("busy", int'(oBusy), 1);
      chk("rden", int'(oRdEn), int'(e_rd));
      chk("rowvalid", int'(oRowValid), int'(e_valid));
      chk("done", int'(oDone), int'(e_done));
      if (e_rd) begin
        chk("waddr", int'(oWAddr), m_rdc);
        chk("xaddr", int'(oXAddr), m_rdc % m_nc);
        if (m_rdc == 0) cap_first_rd = m_t;
        if (m_rdc % m_nc == 0) cap_rs.push_back(m_t);
        cap_waddr.push_back(int'(oWAddr));
        cap_xaddr.push_back(int'(oXAddr));
        m_rdc++;
      end
      if (e_valid) begin
        chk("rowdata", int'(oRowData), int'(exp_row[m_row]));
        chk("rowidx", int'(oRowIdx), m_row);
        if (cap_first_valid < 0) cap_first_valid = m_t;
        if (iRowReady) begin
          cap_data.push_back(int'(oRowData));
          cap_idx.push_back(int'(oRowIdx));
          cap_hs.push_back(m_t);
          if (m_row == m_nr - 1) begin
            m_done_t = m_t + 1;
          end else begin
            m_row++;
            m_rs = m_t + 1;
          end
        end
      end
      if (e_done) begin
        m_active = 0;
        cap_done_t = m_t;
        jobs_done++;
      end
    end else begin
      chk("idle_busy", int'(oBusy), 0);
      chk("idle_rden", int'(oRdEn), 0);
      chk("idle_valid", int'(oRowValid), 0);
      chk("idle_done", int'(oDone), 0);
      if (iStart) begin
        m_active = 1;
        m_t = 0;
        m_nr = int'(iNumRows);
        m_nc = int'(iNumChunks);
        m_row = 0;
        m_rs = 1;
        m_rdc = 0;
        m_done_t = (m_nr == 0 || m_nc == 0) ? 1 : -1;
        cap_first_rd = -1;
        cap_first_valid = -1;
        cap_done_t = -1;
        cap_waddr.delete(); cap_xaddr.delete(); cap_idx.delete();
        cap_data.delete(); cap_hs.delete(); cap_rs.delete();
        jobs_started++;
      end
    end
  end

  task automatic start(input int nr, input int nc);
    @(posedge clk);
    #1;
    iStart = 1'b1;
    iNumRows = 8'(nr);
    iNumChunks = 4'(nc);
    @(posedge clk);
    #1;
    iStart = 1'b0;
  endtask

  task automatic wait_done(input int prev);
    int n = 0;
    while (jobs_done == prev && n < 3000) begin
      @(posedge clk);
      n++;
    end
    chk("job_completes", int'(jobs_done != prev), 1);
    repeat (2) @(posedge clk);
  endtask

  task automatic run(input int nr, input int nc, input int mode);
    int prev = jobs_done;
    prep_job(nr, nc);
    rdy_mode = mode;
    start(nr, nc);
    wait_done(prev);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int ew[6] = '{0, 1, 2, 3, 4, 5};
  int ex[6] = '{0, 1, 0, 1, 0, 1};

  initial begin
    int prev;
    resetn = 1'b0;
    iStart = 1'b0;
    iNumRows = 8'd0;
    iNumChunks = 4'd0;
    for (int i = 0; i < 4096; i++) vals[i] = 0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    repeat (2) @(posedge clk);

    // Single row, single chunk
    vals[0] = 5;
    run(1, 1, 0);
    chk("t1_first_rd", cap_first_rd, 1);
    chk("t1_rd_count", cap_waddr.size(), 1);
    chk("t1_first_valid", cap_first_valid, 4);
    chk("t1_data", cap_data[0], 5);
    chk("t1_done_cycle", cap_done_t, 5);

    // Address sequencing across rows
    for (int i = 0; i < 6; i++) vals[i] = $urandom_range(0, 60) - 30;
    run(3, 2, 0);
    chk("t2_rd_count", cap_waddr.size(), 6);
    for (int i = 0; i < 6; i++) begin
      chk("t2_waddr_seq", cap_waddr[i], ew[i]);
      chk("t2_xaddr_seq", cap_xaddr[i], ex[i]);
    end
    for (int i = 0; i < 3; i++) chk("t2_idx_seq", cap_idx[i], i);

    // Saturation
    for (int i = 0; i < 4; i++) vals[i] = 100;
    run(1, 4, 0);
    chk("sat_pos", cap_data[0], 127);
    for (int i = 0; i < 3; i++) vals[i] = -100;
    run(1, 3, 0);
    chk("sat_neg", cap_data[0], 'h80);
    vals[0] = 60;
    vals[1] = -70;
    run(1, 2, 0);
    chk("sat_mix", cap_data[0], 'hF6);

    // Backpressure on row 0
    for (int i = 0; i < 6; i++) vals[i] = $urandom_range(0, 255) - 128;
    stall_left = 5;
    run(2, 3, 2);
    chk("bp_handshake", cap_hs[0], 11);
    chk("bp_row1_issue", cap_rs[1], 12);

    // Zero configurations
    run(0, 3, 0);
    chk("zero_nr_done", cap_done_t, 1);
    chk("zero_nr_reads", cap_waddr.size(), 0);
    run(2, 0, 0);
    chk("zero_nc_done", cap_done_t, 1);
    chk("zero_nc_reads", cap_waddr.size(), 0);

    // Start while busy is ignored
    for (int i = 0; i < 6; i++) vals[i] = $urandom_range(0, 255) - 128;
    prep_job(2, 3);
    rdy_mode = 0;
    prev = jobs_started;
    start(2, 3);
    repeat (2) @(posedge clk);
    #1 iStart = 1'b1; iNumRows = 8'd5; iNumChunks = 4'd5;
    @(posedge clk);
    #1 iStart = 1'b0;
    wait_done(jobs_done);
    chk("busy_start_jobs", jobs_started, prev + 1);
    chk("busy_start_rows", cap_data.size(), 2);

    // Reset in the middle of issue
    for (int i = 0; i < 8; i++) vals[i] = $urandom_range(0, 255) - 128;
    prep_job(2, 4);
    prev = jobs_done;
    start(2, 4);
    @(posedge clk);
    @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("mid_rst_busy", int'(oBusy), 0);
    chk("mid_rst_rden", int'(oRdEn), 0);
    chk("mid_rst_waddr", int'(oWAddr), 0);
    chk("mid_rst_xaddr", int'(oXAddr), 0);
    repeat (2) @(posedge clk);
    #3 resetn = 1'b1;
    repeat (8) @(posedge clk);
    chk("mid_rst_no_done", jobs_done, prev);
    run(2, 4, 1);
    chk("post_rst_rows", cap_data.size(), 2);

    // Randomized jobs
    for (int j = 0; j < 20; j++) begin
      int nr = $urandom_range(1, 6);
      int nc = $urandom_range(1, 15);
      bit big = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < nr * nc; i++)
        vals[i] = big ? $urandom_range(40, 127) : ($urandom_range(0, 255) - 128);
      run(nr, nc, int'($urandom_range(0, 1)));
      chk("rand_rows", cap_data.size(), nr);
      chk("rand_reads", cap_waddr.size(), nr * nc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lstm_matvec_sequencer.md
Name: lstm_matvec_sequencer

Overview:
- Sequences one 16-lane, 8-bit fixed-point inner-product datapath to compute a matrix-vector product: y[r] = sum over chunks c of the datapath result for (W row r chunk c, x chunk c).
- Issues weight/input buffer reads, tracks the fixed 2-cycle read+datapath pipeline, accumulates the per-chunk 8-bit results, saturates them, and hands each row result downstream on a valid/ready interface.
- Sits between the weight/activation buffers and the LSTM gate/activation stage.

Parameters:
- BIT_WIDTH, 8, width of datapath result and row output (signed two's complement)
- ROW_W, 8, width of row count/index
- CHUNK_W, 4, width of chunk count/index; max 15 chunks of 16 elements per row
- ACC_WIDTH, 12, signed accumulator width; must be >= BIT_WIDTH+CHUNK_W
- ADDR_W, 12, weight address width; equals ROW_W+CHUNK_W

Ports:
- clk  input  1  clock
- resetn  input  1  asynchronous active-low reset
- iStart  input  1  start pulse; sampled only in IDLE
- iNumRows  input  ROW_W  rows to compute; latched on accepted start
- iNumChunks  input  CHUNK_W  16-element chunks per row; latched on accepted start
- oBusy  output  1  high in every state except IDLE
- oDone  output  1  one-cycle pulse when the job completes
- oRdEn  output  1  read strobe to weight and x buffers; buffer data reaches datapath inputs next cycle
- oWAddr  output  ADDR_W  weight chunk address = r*NC + c
- oXAddr  output  CHUNK_W  x chunk address = c
- iInner  input  BIT_WIDTH  registered datapath result; valid exactly 2 cycles after the matching oRdEn cycle
- oRowValid  output  1  row result valid
- oRowData  output  BIT_WIDTH  saturated row result
- oRowIdx  output  ROW_W  index of the row in oRowData
- iRowReady  input  1  downstream accepts when oRowValid && iRowReady

Behaviour:
- Reset: state IDLE; oBusy, oDone, oRdEn, oRowValid = 0; oWAddr, oXAddr, oRowData, oRowIdx, accumulator, all counters = 0. Reset asserted mid-job aborts immediately with no partial output. After release, the block waits for a new iStart.
- States: IDLE, ISSUE, DRAIN, OUT, DONE.
- IDLE:
  - iStart with NR>0 and NC>0: latch NR/NC, clear row, chunk, address counter and accumulator; go to ISSUE.
  - iStart with NR==0 or NC==0: go to DONE; no reads are issued.
  - iStart seen in any other state is ignored.
- ISSUE:
  - oRdEn=1 for exactly NC consecutive cycles, with oXAddr=c=0..NC-1.
  - oWAddr comes from a running counter incremented on every read; it is not reset between rows and no multiplier is used.
  - After the read with c==NC-1, go to DRAIN.
- Pipeline tracking: a 2-stage valid shift register, fed by oRdEn, marks the iInner sample cycles.
  - On each marked cycle: acc <= acc + sign_extend(iInner).
  - The accumulator clears when ISSUE starts for a new row.
- DRAIN: 2 cycles; the final sample lands in the second cycle. Then go to OUT.
- OUT:
  - oRowValid=1, oRowIdx=r.
  - oRowData = acc saturated to [-2^(BIT_WIDTH-1), 2^(BIT_WIDTH-1)-1], i.e. [-128, 127].
  - Data and index hold stable while iRowReady=0; no reads are issued.
  - On handshake: if r==NR-1 go to DONE, else r++ and go to ISSUE.
- DONE: oDone=1 for one cycle; go to IDLE.
- Timing: with start accepted at edge 0, the first oRdEn is in cycle 1. The first oRowValid is in cycle NC+3. Per-row cost is NC+3 cycles plus any backpressure stall.
- Overflow: the accumulator cannot wrap under the parameter rule; saturation is applied only at output.

Test Plan:
- NR=1, NC=1, iInner=5 two cycles after oRdEn -> oRdEn in cycle 1 only; oRowValid in cycle 4 with oRowData=5, oRowIdx=0; iRowReady=1 -> oDone pulse in cycle 5, oBusy=0 in cycle 6.
- NR=3, NC=2, iRowReady=1 -> oWAddr sequence 0,1,2,3,4,5; oXAddr 0,1,0,1,0,1; oRowIdx 0,1,2; exactly one oDone.
- Saturation: NC=4, each chunk iInner=100 -> oRowData=127. NC=3, each chunk iInner=-100 -> oRowData=-128. NC=2 with +60 and -70 -> oRowData=-10.
- Backpressure: hold iRowReady=0 for 5 cycles during row 0 of NR=2 -> oRowValid, oRowData and oRowIdx stay stable; oRdEn=0 throughout; row 1 issue begins the cycle after the handshake.
- Zero config: iStart with NR=0 (or NC=0) -> no oRdEn; oDone pulses in cycle 1. iStart pulsed while busy -> ignored; job count unchanged.
- Reset mid-ISSUE (NR=2, NC=4, resetn low at cycle 3) -> all outputs 0 immediately; no oRowValid/oDone after release. A fresh start then produces correct results.
